// File: rtl/stage_sequencer.sv
// Stage/step schedule generator for the DNN datapath: read-side schedule plus a
// write-side copy delayed by the fixed datapath latency, bracketed by start/busy/done.
module stage_sequencer #(
  parameter int NSTAGE = 12,
  parameter int SW     = 8,
  parameter int LAT    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [SW-1:0] i_n_step,
  input  logic [3:0]    i_last_stage,
  output logic          o_rd_en,
  output logic [3:0]    o_rd_stage,
  output logic [SW-1:0] o_rd_step,
  output logic          o_rd_lstep,
  output logic          o_wr_en,
  output logic [3:0]    o_wr_stage,
  output logic          o_wr_lstep,
  output logic          o_busy,
  output logic          o_done
);

  localparam int             CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [3:0]     MAX_STG  = 4'(NSTAGE - 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_nstep;
  logic [SW-1:0]   r_step;
  logic [3:0]      r_last;
  logic [3:0]      r_stage;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  // Each entry packs {en, stage[3:0], lstep}.
  logic [LAT-1:0][5:0] r_pipe;

  logic            w_run;
  logic            w_lstep;
  logic [5:0]      w_rd_bits;

  assign w_run      = (r_state == S_RUN);
  assign w_lstep    = w_run && (r_step == r_nstep);
  assign o_rd_en    = w_run;
  assign o_rd_stage = w_run ? r_stage : '0;
  assign o_rd_step  = w_run ? r_step  : '0;
  assign o_rd_lstep = w_lstep;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign w_rd_bits  = {w_run, o_rd_stage, w_lstep};

  assign o_wr_en    = r_pipe[LAT-1][5];
  assign o_wr_stage = o_wr_en ? r_pipe[LAT-1][4:1] : '0;
  assign o_wr_lstep = o_wr_en ? r_pipe[LAT-1][0]   : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_rd_bits;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_nstep <= '0;
      r_last  <= '0;
      r_step  <= '0;
      r_stage <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_nstep <= i_n_step;
            r_last  <= (i_last_stage > MAX_STG) ? MAX_STG : i_last_stage;
            r_step  <= '0;
            r_stage <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_step == r_nstep) begin
            r_step <= '0;
            if (r_stage == r_last) begin
              r_stage <= '0;
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_stage <= r_stage + 4'd1;
            end
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        S_DRAIN: begin
          // Hold off done until the last read has reached the write side.
          if (r_cnt == LAST_CNT) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
